// File: rtl/boot_reset_sequencer.sv
// Board-level reset and USB attach sequencer for the tinyfpga bootloader:
// qualifies PLL lock before releasing the core, and detaches USB before warmboot.
module boot_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 4800,
  parameter int unsigned DETACH_CYCLES      = 480000,
  parameter int unsigned CNT_WIDTH          = 20,
  parameter logic [1:0]  BOOT_IMAGE         = 2'b01
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       boot_req,
  output logic       core_reset,
  output logic       usb_pu,
  output logic       warmboot,
  output logic [1:0] warmboot_sel
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RUN       = 2'd1,
    DETACH    = 2'd2,
    BOOT      = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DETACH_LAST = CNT_WIDTH'(DETACH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lock_meta_q, lock_meta_d;
  logic                 lock_sync_q, lock_sync_d;
  logic                 boot_q, boot_d;
  logic                 core_reset_q, core_reset_d;
  logic                 usb_pu_q, usb_pu_d;
  logic                 warmboot_q, warmboot_d;
  logic                 boot_edge;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    lock_meta_d = pll_lock;
    lock_sync_d = lock_meta_q;
    boot_d      = boot_req;
    boot_edge   = boot_req & ~boot_q;
    state_d     = state_q;
    cnt_d       = cnt_q;

    case (state_q)
      WAIT_LOCK: begin
        if (!lock_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // Lock loss wins over a simultaneous boot request.
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (boot_edge) begin
          state_d = DETACH;
          cnt_d   = '0;
        end
      end
      DETACH: begin
        if (cnt_q == DETACH_LAST) begin
          state_d = BOOT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BOOT: begin
        state_d = BOOT;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they register on the same edge as it.
    core_reset_d = (state_d != RUN);
    usb_pu_d     = (state_d == RUN);
    warmboot_d   = (state_d == BOOT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the two sync stages two real stages.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      boot_q       <= 1'b0;
      core_reset_q <= 1'b1;
      usb_pu_q     <= 1'b0;
      warmboot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_meta_q  <= lock_meta_d;
      lock_sync_q  <= lock_sync_d;
      boot_q       <= boot_d;
      core_reset_q <= core_reset_d;
      usb_pu_q     <= usb_pu_d;
      warmboot_q   <= warmboot_d;
    end
  end

  assign core_reset   = core_reset_q;
  assign usb_pu       = usb_pu_q;
  assign warmboot     = warmboot_q;
  assign warmboot_sel = BOOT_IMAGE;

endmodule

// File: tb/tb_boot_reset_sequencer.sv
// Scoreboard bench for boot_reset_sequencer with LOCK_STABLE_CYCLES=8, DETACH_CYCLES=20.
// Expected {core_reset, usb_pu, warmboot, warmboot_sel} is queued per driven cycle.
module tb_boot_reset_sequencer;

  localparam logic [4:0] E_HOLD = 5'b10001;  // core held, pull-up off
  localparam logic [4:0] E_RUN  = 5'b01001;  // core running, pull-up on
  localparam logic [4:0] E_BOOT = 5'b10101;  // warmboot asserted

  logic       clk_48mhz;
  logic       reset_n;
  logic       pll_lock;
  logic       boot_req;
  logic       core_reset;
  logic       usb_pu;
  logic       warmboot;
  logic [1:0] warmboot_sel;
  logic [4:0] obs;

  logic [4:0] sb_q[$];
  logic [4:0] exp_v;
  int         n_cmp = 0;
  int         n_err = 0;

  boot_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .DETACH_CYCLES     (20),
    .CNT_WIDTH         (20),
    .BOOT_IMAGE        (2'b01)
  ) dut (
    .clk_48mhz   (clk_48mhz),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .boot_req    (boot_req),
    .core_reset  (core_reset),
    .usb_pu      (usb_pu),
    .warmboot    (warmboot),
    .warmboot_sel(warmboot_sel)
  );

  assign obs = {core_reset, usb_pu, warmboot, warmboot_sel};

  initial clk_48mhz = 1'b0;
  always #5 clk_48mhz = ~clk_48mhz;

  // Untimed-check helper: reset, then run 10 locked edges into RUN.
  task automatic reset_to_run();
    reset_n  = 1'b0;
    pll_lock = 1'b1;
    boot_req = 1'b0;
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    repeat (10) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
  endtask

  task automatic test_reset();
    reset_n  = 1'b1;
    pll_lock = 1'b0;
    boot_req = 1'b0;
    #2 reset_n = 1'b0;
    sb_q.push_back(E_HOLD);
    #1;
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_async: got %b want %b", obs, exp_v);
    end
    for (int i = 1; i <= 2; i++) begin
      pll_lock = 1'b1;
      sb_q.push_back(E_HOLD);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_held edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    @(negedge clk_48mhz);
  endtask

  task automatic test_lock_release();
    pll_lock = 1'b1;
    boot_req = 1'b0;
    reset_n  = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      sb_q.push_back(i < 10 ? E_HOLD : E_RUN);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL lock_release edge %0d: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk_48mhz);
    end
  endtask

  task automatic test_boot_pulse();
    // Edge 0 enters DETACH; warmboot appears on edge 20 and then holds.
    for (int i = 0; i <= 1020; i++) begin
      boot_req = (i == 0);
      if (i >= 21)              pll_lock = 1'($urandom_range(0, 1));
      else if (i >= 5 && i <= 8) pll_lock = 1'b0;
      else                       pll_lock = 1'b1;
      if (i >= 5 && i <= 8) boot_req = i[0];
      if (i >= 21)          boot_req = 1'($urandom_range(0, 1));
      sb_q.push_back(i < 20 ? E_HOLD : E_BOOT);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL boot_pulse edge %0d: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk_48mhz);
    end
  endtask

  task automatic test_lock_glitch();
    reset_n  = 1'b0;
    pll_lock = 1'b1;
    boot_req = 1'b0;
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    // Five locked edges, one unlocked edge, then 12 locked edges.
    for (int i = 1; i <= 18; i++) begin
      pll_lock = (i != 6);
      sb_q.push_back(i < 16 ? E_HOLD : E_RUN);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL lock_glitch edge %0d: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk_48mhz);
    end
  endtask

  task automatic test_boot_held();
    reset_n  = 1'b0;
    pll_lock = 1'b1;
    boot_req = 1'b1;
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    // Held through RUN entry (edges 1..15), low on 16..17, rises on 18.
    for (int i = 1; i <= 21; i++) begin
      boot_req = !(i == 16 || i == 17);
      if (i < 10 || i >= 18) sb_q.push_back(E_HOLD);
      else                   sb_q.push_back(E_RUN);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL boot_held edge %0d: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk_48mhz);
    end
    boot_req = 1'b0;
  endtask

  task automatic test_lock_loss();
    reset_to_run();
    // Lock low for edges 1..5, restored before edge 6, RUN again on edge 15.
    for (int i = 1; i <= 16; i++) begin
      pll_lock = (i > 5);
      if (i < 3 || i >= 15) sb_q.push_back(E_RUN);
      else                  sb_q.push_back(E_HOLD);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL lock_loss edge %0d: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk_48mhz);
    end
    // Boot edge coincides with lock_sync falling (edge 3): must not detach.
    for (int i = 1; i <= 15; i++) begin
      pll_lock = (i > 3);
      boot_req = (i == 3);
      if (i < 3 || i >= 13) sb_q.push_back(E_RUN);
      else                  sb_q.push_back(E_HOLD);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL lock_vs_boot edge %0d: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk_48mhz);
    end
  endtask

  task automatic test_reset_mid_detach();
    reset_to_run();
    for (int i = 0; i <= 12; i++) begin
      boot_req = (i == 0);
      sb_q.push_back(E_HOLD);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL mid_detach edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    #2 reset_n = 1'b0;
    sb_q.push_back(E_HOLD);
    #1;
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL mid_detach_reset: got %b want %b", obs, exp_v);
    end
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      sb_q.push_back(i < 10 ? E_HOLD : E_RUN);
      @(posedge clk_48mhz); #1;
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL post_reset edge %0d: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk_48mhz);
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    pll_lock = 1'b0;
    boot_req = 1'b0;
    test_reset();
    test_lock_release();
    test_boot_pulse();
    test_lock_glitch();
    test_boot_held();
    test_lock_loss();
    test_reset_mid_detach();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
